// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: segment sequencer driving a 4-bit up/down counter's MIN/MAX/MODE/SS
// Ports: Clk/RST (async, active-high); CFG_WE/CFG_ADDR/CFG_DATA write the segment table
// {LOOPS,MODE,MAX,MIN}; LAST_SEG/START/STOP/PAUSE control the run; CNT_IN is the counter value;
// MIN_O/MAX_O/MODE_O/SS_O drive the counter; SEG_IDX/BUSY/DONE/WRAP report status.
// CNTSEQ_CONTINUOUS_EN adds input CONT: when high, finishing LAST_SEG restarts at segment 0.
module counter_seq_ctrl #(
  parameter int DEPTH = 4,
  parameter int LOOP_W = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = 9 + LOOP_W
) (
  input  logic          Clk,
  input  logic          RST,
  input  logic          CFG_WE,
  input  logic [AW-1:0] CFG_ADDR,
  input  logic [DW-1:0] CFG_DATA,
  input  logic [AW-1:0] LAST_SEG,
  input  logic          START,
  input  logic          STOP,
  input  logic          PAUSE,
`ifdef CNTSEQ_CONTINUOUS_EN
  input  logic          CONT,
`endif
  input  logic [3:0]    CNT_IN,
  output logic [3:0]    MIN_O,
  output logic [3:0]    MAX_O,
  output logic          MODE_O,
  output logic          SS_O,
  output logic [AW-1:0] SEG_IDX,
  output logic          BUSY,
  output logic          DONE,
  output logic          WRAP
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
  state_t state, nxt;
  logic [DW-1:0] tab [DEPTH];
  logic [AW-1:0] last, nxt_seg;
  logic [LOOP_W-1:0] loops, cnt, cnt_inc;
  logic cont, idle_like, at_last, adv;
`ifdef CNTSEQ_CONTINUOUS_EN
  assign cont = CONT;
`else
  assign cont = 1'b0;
`endif
  assign idle_like = state == S_IDLE || state == S_DONE;
  assign loops = tab[SEG_IDX][DW-1:9];
  assign cnt_inc = cnt + 1'b1;
  assign at_last = SEG_IDX == last;
  assign WRAP = state == S_RUN && SS_O && CNT_IN == (MODE_O ? MAX_O : MIN_O);
  assign BUSY = state == S_LOAD || state == S_RUN;
  assign DONE = state == S_DONE;
  // a zero-loop entry is skipped straight from LOAD; otherwise the segment ends on its last wrap
  assign adv = state == S_LOAD ? loops == '0 : WRAP && cnt_inc == loops;
  always_comb begin
    nxt = state;
    nxt_seg = at_last ? '0 : SEG_IDX + 1'b1;
    if (STOP) nxt = S_IDLE;
    else if (idle_like && START) begin
      nxt = S_LOAD;
      nxt_seg = '0;
    end
    else if (state == S_LOAD && !adv) nxt = S_RUN;
    else if (adv) nxt = at_last && !cont ? S_DONE : S_LOAD;
  end
  always_ff @(posedge Clk or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      SEG_IDX <= '0;
      last <= '0;
      cnt <= '0;
      MIN_O <= '0;
      MAX_O <= '0;
      MODE_O <= 1'b0;
      SS_O <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tab[i] <= {LOOP_W'(1), 1'b1, 4'hf, 4'h0};
    end else begin
      state <= nxt;
      SS_O <= nxt == S_RUN && (state == S_LOAD || !PAUSE);
      cnt <= state == S_RUN && nxt == S_RUN ? cnt + LOOP_W'(WRAP) : '0;
      if (nxt == S_LOAD) begin
        SEG_IDX <= nxt_seg;
        {MODE_O, MAX_O, MIN_O} <= tab[nxt_seg][8:0];
      end
      if (idle_like && START && !STOP) last <= LAST_SEG;
      if (idle_like && CFG_WE) tab[CFG_ADDR] <= CFG_DATA;
    end
  end
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: randomized self-checking bench for counter_seq_ctrl with a behavioural counter
module tb_counter_seq_ctrl;
  logic Clk = 1'b0, RST = 1'b1, CFG_WE = 1'b0, START = 1'b0, STOP = 1'b0, PAUSE = 1'b0;
  logic [1:0] CFG_ADDR = '0, LAST_SEG = '0, SEG_IDX;
  logic [12:0] CFG_DATA = '0;
  logic [3:0] CNT_IN = '0, MIN_O, MAX_O, pre_val = '0;
  logic MODE_O, SS_O, BUSY, DONE, WRAP, pre_en = 1'b0;
`ifdef CNTSEQ_CONTINUOUS_EN
  logic CONT = 1'b0;
`endif
  int n_chk = 0, n_fail = 0;
  typedef struct packed {logic [1:0] seg; logic ss, wrap; logic [3:0] mn, mx; logic md;} ev_t;
  ev_t tl[$];
  logic [12:0] mtab [4];

  counter_seq_ctrl dut (
    .Clk(Clk), .RST(RST), .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
    .LAST_SEG(LAST_SEG), .START(START), .STOP(STOP), .PAUSE(PAUSE),
`ifdef CNTSEQ_CONTINUOUS_EN
    .CONT(CONT),
`endif
    .CNT_IN(CNT_IN), .MIN_O(MIN_O), .MAX_O(MAX_O), .MODE_O(MODE_O), .SS_O(SS_O),
    .SEG_IDX(SEG_IDX), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP)
  );

  always #5 Clk = ~Clk;

  // the 4-bit up/down counter the sequencer controls
  always @(posedge Clk)
    CNT_IN <= pre_en ? pre_val : !SS_O ? CNT_IN :
              MODE_O ? (CNT_IN == MAX_O ? MIN_O : CNT_IN + 4'd1) :
                       (CNT_IN == MIN_O ? MAX_O : CNT_IN - 4'd1);

  task automatic table_defaults();
    for (int i = 0; i < 4; i++) mtab[i] = {4'd1, 1'b1, 4'd15, 4'd0};
  endtask

  task automatic wr(input logic [1:0] a, input logic [12:0] d);
    CFG_WE = 1'b1;
    CFG_ADDR = a;
    CFG_DATA = d;
    @(negedge Clk);
    CFG_WE = 1'b0;
    mtab[a] = d;
  endtask

  // expected per-cycle timeline: one LOAD cycle per segment, then distance-to-terminal plus
  // (LOOPS-1) full periods of run cycles, wrapping at the terminal value each period
  task automatic build(input int last, input logic [3:0] c0);
    ev_t e;
    logic [3:0] c, dd;
    int l, p;
    c = c0;
    tl.delete();
    for (int s = 0; s <= last; s++) begin
      l = int'(mtab[s][12:9]);
      e.seg = 2'(s);
      e.md = mtab[s][8];
      e.mx = mtab[s][7:4];
      e.mn = mtab[s][3:0];
      e.ss = 1'b0;
      e.wrap = 1'b0;
      tl.push_back(e);
      if (l == 0) continue;
      dd = e.md ? e.mx - c : c - e.mn;
      p = int'(e.mx) - int'(e.mn) + 1;
      e.ss = 1'b1;
      for (int j = 0; j <= int'(dd) + (l - 1) * p; j++) begin
        e.wrap = j >= int'(dd) && (j - int'(dd)) % p == 0;
        tl.push_back(e);
      end
      c = e.md ? e.mn : e.mx;
    end
  endtask

  task automatic run_seq(input int last, input logic [3:0] c0, input int pause_at);
    ev_t e;
    pre_en = 1'b1;
    pre_val = c0;
    @(negedge Clk);
    pre_en = 1'b0;
    build(last, c0);
    if (pause_at >= 0) begin
      e = tl[pause_at];
      e.ss = 1'b0;
      e.wrap = 1'b0;
      repeat (5) tl.insert(pause_at + 1, e);
    end
    LAST_SEG = 2'(last);
    START = 1'b1;
    @(negedge Clk);
    START = 1'b0;
    foreach (tl[t]) begin
      n_chk++;
      if ({SEG_IDX, SS_O, BUSY, WRAP, DONE, MIN_O, MAX_O, MODE_O} !==
          {tl[t].seg, tl[t].ss, 1'b1, tl[t].wrap, 1'b0, tl[t].mn, tl[t].mx, tl[t].md}) begin
        n_fail++;
        $display("FAIL seq cycle %0d: got seg=%0d ss=%b busy=%b wrap=%b done=%b min=%0d max=%0d mode=%b, expected seg=%0d ss=%b busy=1 wrap=%b done=0 min=%0d max=%0d mode=%b",
                 t, SEG_IDX, SS_O, BUSY, WRAP, DONE, MIN_O, MAX_O, MODE_O,
                 tl[t].seg, tl[t].ss, tl[t].wrap, tl[t].mn, tl[t].mx, tl[t].md);
      end
      if (pause_at >= 0 && t == pause_at) PAUSE = 1'b1;
      if (pause_at >= 0 && t == pause_at + 5) PAUSE = 1'b0;
      @(negedge Clk);
    end
    n_chk++;
    if ({DONE, BUSY, SS_O, WRAP} !== 4'b1000) begin
      n_fail++;
      $display("FAIL seq end: done/busy/ss/wrap=%b expected 1000", {DONE, BUSY, SS_O, WRAP});
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    n_chk++;
    if ({MIN_O, MAX_O, MODE_O, SS_O, SEG_IDX, BUSY, DONE, WRAP} !== '0) begin
      n_fail++;
      $display("FAIL reset outputs: got %h expected 0", {MIN_O, MAX_O, MODE_O, SS_O, SEG_IDX, BUSY, DONE, WRAP});
    end
    RST = 1'b0;
    table_defaults();
    @(negedge Clk);
  endtask

  task automatic test_default();
    run_seq(0, 4'd0, -1);
  endtask

  task automatic test_two_seg();
    wr(2'd0, {4'd2, 1'b1, 4'd6, 4'd3});
    wr(2'd1, {4'd1, 1'b0, 4'd9, 4'd2});
    run_seq(1, 4'd3, -1);
  endtask

  task automatic test_skip();
    wr(2'd1, {4'd0, 1'b1, 4'd9, 4'd1});
    wr(2'd2, {4'd1, 1'b0, 4'd5, 4'd4});
    run_seq(2, 4'd7, -1);
  endtask

  task automatic test_pause();
    wr(2'd0, {4'd2, 1'b1, 4'd7, 4'd0});
    run_seq(0, 4'd0, 4);
  endtask

  task automatic test_stop_start();
    wr(2'd0, {4'd1, 1'b1, 4'd3, 4'd0});
    wr(2'd1, {4'd3, 1'b1, 4'd12, 4'd5});
    pre_en = 1'b1;
    pre_val = 4'd0;
    @(negedge Clk);
    pre_en = 1'b0;
    LAST_SEG = 2'd1;
    START = 1'b1;
    @(negedge Clk);
    START = 1'b0;
    repeat (7) @(negedge Clk);
    CFG_WE = 1'b1;
    CFG_ADDR = 2'd1;
    CFG_DATA = {4'd1, 1'b0, 4'd15, 4'd15};
    @(negedge Clk);
    CFG_WE = 1'b0;
    @(negedge Clk);
    STOP = 1'b1;
    START = 1'b1;
    @(negedge Clk);
    STOP = 1'b0;
    START = 1'b0;
    n_chk++;
    if ({BUSY, DONE, SS_O} !== 3'b000) begin
      n_fail++;
      $display("FAIL stop state: busy/done/ss=%b expected 000", {BUSY, DONE, SS_O});
    end
    n_chk++;
    if ({SEG_IDX, MIN_O, MAX_O, MODE_O} !== {2'd1, 4'd5, 4'd12, 1'b1}) begin
      n_fail++;
      $display("FAIL stop hold: seg=%0d min=%0d max=%0d mode=%b expected 1 5 12 1", SEG_IDX, MIN_O, MAX_O, MODE_O);
    end
    run_seq(1, 4'd0, -1);
  endtask

  task automatic test_random();
    logic [3:0] mn;
    repeat (6) begin
      for (int a = 0; a < 4; a++) begin
        mn = 4'($urandom_range(0, 15));
        wr(2'(a), {4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom_range(int'(mn), 15)), mn});
      end
      run_seq(int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), -1);
    end
  endtask

  task automatic test_reset_mid_run();
    wr(2'd0, {4'd3, 1'b0, 4'd14, 4'd2});
    LAST_SEG = 2'd0;
    START = 1'b1;
    @(negedge Clk);
    START = 1'b0;
    repeat (3) @(negedge Clk);
    RST = 1'b1;
    #1;
    n_chk++;
    if ({MIN_O, MAX_O, MODE_O, SS_O, SEG_IDX, BUSY, DONE, WRAP} !== '0) begin
      n_fail++;
      $display("FAIL async reset: got %h expected 0", {MIN_O, MAX_O, MODE_O, SS_O, SEG_IDX, BUSY, DONE, WRAP});
    end
    @(negedge Clk);
    RST = 1'b0;
    table_defaults();
    run_seq(3, 4'd5, -1);
  endtask

`ifdef CNTSEQ_CONTINUOUS_EN
  task automatic test_continuous();
    int seen[$];
    int dones = 0;
    wr(2'd0, {4'd1, 1'b1, 4'd2, 4'd0});
    wr(2'd1, {4'd1, 1'b0, 4'd2, 4'd0});
    CONT = 1'b1;
    LAST_SEG = 2'd1;
    START = 1'b1;
    @(negedge Clk);
    START = 1'b0;
    seen.push_back(int'(SEG_IDX));
    for (int c = 0; c < 200 && seen.size() < 4; c++) begin
      @(negedge Clk);
      if (DONE) dones++;
      if (int'(SEG_IDX) != seen[seen.size() - 1]) seen.push_back(int'(SEG_IDX));
    end
    n_chk++;
    if (seen.size() < 4) begin
      n_fail++;
      $display("FAIL cont timeout: %0d segment changes seen expected 4", seen.size());
    end
    foreach (seen[i]) begin
      n_chk++;
      if (seen[i] != i % 2) begin
        n_fail++;
        $display("FAIL cont seg order %0d: got %0d expected %0d", i, seen[i], i % 2);
      end
    end
    n_chk++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL cont done: %0d cycles with DONE=1 expected 0", dones);
    end
    STOP = 1'b1;
    @(negedge Clk);
    STOP = 1'b0;
    CONT = 1'b0;
    n_chk++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL cont stop: busy=%b expected 0", BUSY);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_default();
    test_two_seg();
    test_skip();
    test_pause();
    test_stop_start();
    test_random();
    test_reset_mid_run();
`ifdef CNTSEQ_CONTINUOUS_EN
    test_continuous();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Segment sequencer for the 4-bit up/down counter.
- Holds a table of DEPTH segments; each segment is {MIN, MAX, MODE, LOOPS}.
- Drives the counter's MIN/MAX/MODE/SS inputs and watches its OUT value.
- Advances to the next segment after LOOPS wrap events. Sits between the register/config logic and a counter instance.

Parameters:
- DEPTH, 4, number of segment table entries (power of two, >=2).
- LOOP_W, 4, width of the per-segment wrap-count field.

Ports:
- Clk  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- CFG_WE  in  1  table write strobe.
- CFG_ADDR  in  log2(DEPTH)  table write index.
- CFG_DATA  in  9+LOOP_W  {LOOPS, MODE, MAX[3:0], MIN[3:0]}, MSB..LSB.
- LAST_SEG  in  log2(DEPTH)  index of final segment, sampled on accepted START.
- START  in  1  begin sequence at segment 0.
- STOP  in  1  abort to IDLE.
- PAUSE  in  1  level; hold the counter while high.
- CNT_IN  in  4  counter OUT value.
- MIN_O  out  4  to counter MIN.
- MAX_O  out  4  to counter MAX.
- MODE_O  out  1  to counter MODE (1 = up).
- SS_O  out  1  to counter SS.
- SEG_IDX  out  log2(DEPTH)  current segment.
- BUSY  out  1  state is LOAD or RUN.
- DONE  out  1  state is DONE.
- WRAP  out  1  combinational wrap-event indicator.

Behaviour:
- Reset (async):
  - State IDLE; all outputs 0; loop counter 0.
  - Every table entry = {LOOPS=1, MODE=1, MAX=15, MIN=0}.
- Table writes: CFG_WE takes effect only in IDLE or DONE; ignored in LOAD/RUN.
- States: IDLE, LOAD, RUN, DONE.
- IDLE/DONE:
  - START=1 -> LOAD with SEG_IDX=0; LAST_SEG latched; DONE cleared.
- LOAD (1 cycle, SS_O=0):
  - MIN_O/MAX_O/MODE_O are registered from table[SEG_IDX] on the edge entering LOAD.
  - Loop counter cleared.
  - If entry LOOPS==0, the segment is skipped: SEG_IDX+1 -> LOAD, or -> DONE if SEG_IDX==LAST_SEG.
  - Otherwise -> RUN; SS_O=1 from that edge.
- RUN:
  - SS_O(next) = !PAUSE (one-cycle registered latency).
  - Terminal value = MAX_O if MODE_O=1, else MIN_O.
  - WRAP = (state==RUN) & SS_O & (CNT_IN==terminal). The counter wraps on that same edge.
  - On each WRAP edge the loop counter increments.
  - When loop counter+1 == LOOPS at a WRAP edge: -> LOAD of SEG_IDX+1 (SS_O=0), or -> DONE if SEG_IDX==LAST_SEG.
- Counter value outside [MIN,MAX] at segment entry: no correction; the counter runs through the 4-bit wrap until it reaches the terminal value.
- Latency: START edge k -> LOAD; SS_O=1 from edge k+1; first counter step at edge k+2.
- Priority: STOP > START > PAUSE.
  - STOP in any state -> IDLE, SS_O=0 next edge.
  - MIN_O/MAX_O/MODE_O/SEG_IDX hold their values; DONE cleared.
- START in LOAD/RUN is ignored.
- Reset mid-RUN: immediate IDLE, outputs 0, table reinitialised.

Optional Feature:
- Macro: CNTSEQ_CONTINUOUS_EN.
- Defined: adds input CONT (1 bit). When CONT=1, completing segment LAST_SEG returns to LOAD of segment 0 and DONE is never entered. STOP still aborts.
- Undefined: no CONT port; completion of LAST_SEG always -> DONE.

Test Plan:
- Reset, then START with LAST_SEG=0, default table, counter starting at 0 -> SS_O=1 two edges after START; WRAP when CNT_IN=15; DONE=1, SS_O=0 after that edge.
- Table seg0={LOOPS=2,up,MIN=3,MAX=6}, seg1={LOOPS=1,down,MIN=2,MAX=9}, LAST_SEG=1 -> two wraps at 6, one LOAD cycle with SS_O=0, MODE_O=0, one wrap at 2, then DONE.
- Seg1 LOOPS=0, LAST_SEG=2 -> seg1 skipped; SEG_IDX 0 -> 1 -> 2 with one LOAD cycle each.
- PAUSE held 5 cycles mid-RUN -> SS_O=0 one edge after PAUSE rises; no WRAP; loop count preserved; resumes one edge after PAUSE falls.
- STOP and START on the same edge during RUN -> IDLE; CFG_WE during RUN leaves the table unchanged (read back via a later run).
- With CNTSEQ_CONTINUOUS_EN, CONT=1, LAST_SEG=1 -> SEG_IDX cycles 0,1,0,1; DONE stays 0.
